// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types, widths and helpers for the PWM channel sequencer
package pwm_pkg;
    typedef enum logic [1:0] {PWM_IDLE, PWM_ARMED, PWM_RUN, PWM_DONE} pwm_state_t;
    localparam int PWM_CNT_W   = 16;
    localparam int PWM_SCALE_W = 4;
    localparam int PWM_PRESC_W = 1 << PWM_SCALE_W;
    // Terminal prescaler value for a given scale: 2^scale-1
    function automatic logic [PWM_PRESC_W-1:0] presc_mask(input logic [PWM_SCALE_W-1:0] scale);
        return ~({PWM_PRESC_W{1'b1}} << scale);
    endfunction
endpackage

// File: rtl/pwm_trig_sync.sv
// pwm_trig_sync: GPIO trigger select, 2-flop synchroniser and registered edge detect
module pwm_trig_sync #(
    parameter int NGPIO = 8
) (
    input  logic             mclk,
    input  logic             h_reset_n,
    input  logic [NGPIO-1:0] gpio_in,
    input  logic [2:0]       sel,
    input  logic             trig_edge,
    output logic             trig
);
    logic raw, s1, s2, s3;
    assign raw = (32'(sel) < NGPIO) ? gpio_in[sel] : 1'b0;
    always_ff @(posedge mclk or negedge h_reset_n) begin
        if (!h_reset_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            trig <= 1'b0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            s3   <= s2;
            trig <= trig_edge ? (s3 & ~s2) : (s2 & ~s3);
        end
    end
endmodule

// File: rtl/pwm_seq_ctrl.sv
// pwm_seq_ctrl: PWM channel sequencer - prescaler, period counter, start/restart FSM
// and config shadow update strobe.
module pwm_seq_ctrl
    import pwm_pkg::*;
#(
    parameter int NGPIO = 8,
    parameter int CNT_W = PWM_CNT_W
) (
    input  logic                   mclk,
    input  logic                   h_reset_n,
    input  logic                   cfg_pwm_enb,
    input  logic [PWM_SCALE_W-1:0] cfg_pwm_scale,
    input  logic                   cfg_pwm_oneshot,
    input  logic                   cfg_pwm_frun,
    input  logic                   cfg_pwm_gpio_enb,
    input  logic                   cfg_pwm_gpio_edge,
    input  logic [2:0]             cfg_pwm_gpio_sel,
    input  logic [CNT_W-1:0]       cfg_pwm_period,
    input  logic [NGPIO-1:0]       gpio_in,
    output logic [CNT_W-1:0]       pwm_cnt,
    output logic                   pwm_tick,
    output logic                   pwm_run,
    output logic                   pwm_cfg_update,
    output logic                   pwm_done
);
    pwm_state_t             state, state_d;
    logic [PWM_SCALE_W-1:0] scale_q;
    logic [PWM_PRESC_W-1:0] presc, presc_d;
    logic [CNT_W-1:0]       cnt_d;
    logic                   trig, adv, roll, running, upd_d, done_d, tick_d;

    pwm_trig_sync #(.NGPIO(NGPIO)) u_trig (
        .mclk      (mclk),
        .h_reset_n (h_reset_n),
        .gpio_in   (gpio_in),
        .sel       (cfg_pwm_gpio_sel),
        .trig_edge (cfg_pwm_gpio_edge),
        .trig      (trig)
    );

    assign pwm_run = state == PWM_RUN;

    always_comb begin
        running = state == PWM_RUN && cfg_pwm_enb;
        adv     = state == PWM_RUN && presc == presc_mask(scale_q);
        // >= also catches a period lowered below the current count
        roll    = adv && pwm_cnt >= cfg_pwm_period;
        state_d = state;
        if (!cfg_pwm_enb)
            state_d = PWM_IDLE;
        else if (state == PWM_IDLE)
            state_d = cfg_pwm_gpio_enb ? PWM_ARMED : PWM_RUN;
        else if (state == PWM_ARMED && trig)
            state_d = PWM_RUN;
        else if (state == PWM_RUN && roll)
            state_d = cfg_pwm_oneshot ? PWM_DONE :
                      (cfg_pwm_frun || !cfg_pwm_gpio_enb) ? PWM_RUN : PWM_ARMED;
        presc_d = (running && !adv) ? presc + 1'b1 : '0;
        cnt_d   = !running ? '0 : roll ? '0 : adv ? pwm_cnt + 1'b1 : pwm_cnt;
        upd_d   = state_d == PWM_IDLE || (roll && cfg_pwm_enb);
        done_d  = roll && cfg_pwm_enb && cfg_pwm_oneshot;
        tick_d  = adv && cfg_pwm_enb;
    end

    always_ff @(posedge mclk or negedge h_reset_n) begin
        if (!h_reset_n)
            state <= PWM_IDLE;
        else
            state <= state_d;
    end

    always_ff @(posedge mclk or negedge h_reset_n) begin
        if (!h_reset_n) begin
            scale_q        <= '0;
            presc          <= '0;
            pwm_cnt        <= '0;
            pwm_tick       <= 1'b0;
            pwm_cfg_update <= 1'b0;
            pwm_done       <= 1'b0;
        end else begin
            // scale is only picked up at a prescaler wrap or while not counting
            if (state != PWM_RUN || adv)
                scale_q <= cfg_pwm_scale;
            presc          <= presc_d;
            pwm_cnt        <= cnt_d;
            pwm_tick       <= tick_d;
            pwm_cfg_update <= upd_d;
            pwm_done       <= done_d;
        end
    end
endmodule

// File: tb/tb_pwm_seq_ctrl.sv
// tb_pwm_seq_ctrl: directed self-checking bench for pwm_seq_ctrl
module tb_pwm_seq_ctrl;
    logic        mclk = 1'b0;
    logic        h_reset_n = 1'b0;
    logic        cfg_pwm_enb = 1'b0;
    logic [3:0]  cfg_pwm_scale = '0;
    logic        cfg_pwm_oneshot = 1'b0;
    logic        cfg_pwm_frun = 1'b0;
    logic        cfg_pwm_gpio_enb = 1'b0;
    logic        cfg_pwm_gpio_edge = 1'b0;
    logic [2:0]  cfg_pwm_gpio_sel = '0;
    logic [15:0] cfg_pwm_period = '0;
    logic [7:0]  gpio_in = 8'hff;
    logic [15:0] pwm_cnt;
    logic        pwm_tick, pwm_run, pwm_cfg_update, pwm_done;
    int          n_chk = 0;
    int          n_pass = 0;
    int          s, p;

    pwm_seq_ctrl dut (
        .mclk              (mclk),
        .h_reset_n         (h_reset_n),
        .cfg_pwm_enb       (cfg_pwm_enb),
        .cfg_pwm_scale     (cfg_pwm_scale),
        .cfg_pwm_oneshot   (cfg_pwm_oneshot),
        .cfg_pwm_frun      (cfg_pwm_frun),
        .cfg_pwm_gpio_enb  (cfg_pwm_gpio_enb),
        .cfg_pwm_gpio_edge (cfg_pwm_gpio_edge),
        .cfg_pwm_gpio_sel  (cfg_pwm_gpio_sel),
        .cfg_pwm_period    (cfg_pwm_period),
        .gpio_in           (gpio_in),
        .pwm_cnt           (pwm_cnt),
        .pwm_tick          (pwm_tick),
        .pwm_run           (pwm_run),
        .pwm_cfg_update    (pwm_cfg_update),
        .pwm_done          (pwm_done)
    );

    always #5 mclk = ~mclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge mclk);
    endtask

    task automatic chk_all0(input string tag);
        chk({tag, "_cnt"}, pwm_cnt, 0);
        chk({tag, "_tick"}, pwm_tick, 0);
        chk({tag, "_run"}, pwm_run, 0);
        chk({tag, "_upd"}, pwm_cfg_update, 0);
        chk({tag, "_done"}, pwm_done, 0);
    endtask

    initial begin
        #1 chk_all0("rst");
        @(negedge mclk) h_reset_n = 1'b1;
        step(1);
        chk("idle_upd", pwm_cfg_update, 1);
        chk("idle_run", pwm_run, 0);

        // 1: free-run, scale 0, period 3
        cfg_pwm_scale = 4'd0; cfg_pwm_period = 16'd3; cfg_pwm_frun = 1'b1; cfg_pwm_enb = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step(1);
            chk("t1_cnt", pwm_cnt, (k - 1) % 4);
            chk("t1_upd", pwm_cfg_update, (k >= 5 && (k - 1) % 4 == 0));
            chk("t1_run", pwm_run, 1);
        end

        // 2: one-shot, scale 2, period 1
        cfg_pwm_enb = 1'b0; step(2);
        cfg_pwm_scale = 4'd2; cfg_pwm_period = 16'd1; cfg_pwm_oneshot = 1'b1; cfg_pwm_frun = 1'b0;
        cfg_pwm_enb = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            step(1);
            chk("t2_tick", pwm_tick, k == 5 || k == 9);
            chk("t2_cnt", pwm_cnt, k >= 5 && k <= 8);
            chk("t2_done", pwm_done, k == 9);
            chk("t2_run", pwm_run, k <= 8);
            chk("t2_upd", pwm_cfg_update, k == 9);
        end

        // 3: GPIO falling-edge start on gpio_in[5], re-arm after roll-over
        cfg_pwm_enb = 1'b0; step(2);
        cfg_pwm_oneshot = 1'b0; cfg_pwm_scale = 4'd0; cfg_pwm_period = 16'd2;
        cfg_pwm_gpio_enb = 1'b1; cfg_pwm_gpio_sel = 3'd5; cfg_pwm_gpio_edge = 1'b1;
        cfg_pwm_enb = 1'b1;
        step(5);
        chk("t3_armed_run", pwm_run, 0);
        chk("t3_armed_upd", pwm_cfg_update, 0);
        gpio_in[5] = 1'b0;
        step(2);
        chk("t3_sync_run", pwm_run, 0);
        step(2);
        chk("t3_trig_run", pwm_run, 1);
        chk("t3_trig_cnt", pwm_cnt, 0);
        step(1); chk("t3_cnt1", pwm_cnt, 1);
        step(1); chk("t3_cnt2", pwm_cnt, 2);
        step(1);
        chk("t3_roll_cnt", pwm_cnt, 0);
        chk("t3_roll_upd", pwm_cfg_update, 1);
        chk("t3_rearm_run", pwm_run, 0);
        gpio_in[5] = 1'b1;
        step(6);
        chk("t3_rise_ignored", pwm_run, 0);
        chk("t3_rearm_upd", pwm_cfg_update, 0);

        // 4: enb drop at cnt 7 just before a one-shot roll-over
        cfg_pwm_enb = 1'b0; step(2);
        cfg_pwm_gpio_enb = 1'b0; cfg_pwm_oneshot = 1'b1; cfg_pwm_period = 16'd7;
        cfg_pwm_enb = 1'b1;
        step(8);
        chk("t4_cnt7", pwm_cnt, 7);
        cfg_pwm_enb = 1'b0;
        step(1);
        chk("t4_cnt", pwm_cnt, 0);
        chk("t4_run", pwm_run, 0);
        chk("t4_upd", pwm_cfg_update, 1);
        chk("t4_done", pwm_done, 0);

        // 5: period lowered below current count
        step(1);
        cfg_pwm_oneshot = 1'b0; cfg_pwm_frun = 1'b1; cfg_pwm_period = 16'd100;
        cfg_pwm_enb = 1'b1;
        step(51);
        chk("t5_cnt50", pwm_cnt, 50);
        cfg_pwm_period = 16'd2;
        step(1);
        chk("t5_roll_cnt", pwm_cnt, 0);
        chk("t5_roll_upd", pwm_cfg_update, 1);
        step(1); chk("t5_cnt1", pwm_cnt, 1); chk("t5_upd1", pwm_cfg_update, 0);
        step(1); chk("t5_cnt2", pwm_cnt, 2);
        step(1); chk("t5_cnt0", pwm_cnt, 0); chk("t5_upd2", pwm_cfg_update, 1);

        // 6: asynchronous reset mid-run with random config
        s = $urandom_range(0, 2);
        p = $urandom_range(5, 50);
        cfg_pwm_scale = 4'(s); cfg_pwm_period = 16'(p);
        step(7);
        #2 h_reset_n = 1'b0;
        #1 chk_all0("t6_async");
        @(negedge mclk);
        chk_all0("t6_held");
        h_reset_n = 1'b1;
        step(1);
        chk("t6_resume_run", pwm_run, 1);
        chk("t6_resume_cnt", pwm_cnt, 0);
        step(1 << s);
        chk("t6_first_tick", pwm_tick, 1);
        chk("t6_first_cnt", pwm_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
